vga_sdram_arbiter: RTL and testbench
====================================

Name: vga_sdram_arbiter

Overview:
- Two-requester arbiter in front of the single 16-bit SDRAM port of the VGA display subsystem.
- Requester 0 is the scan-out fetch path: latency-critical, fixed high priority.
- Requester 1 is the bus write/clear path; a starvation counter guarantees it service.
- The block holds one registered command slot toward SDRAM and a tag FIFO that routes read returns back to the issuing requester in order.

Parameters:
- TAG_DEPTH, 8, max outstanding SDRAM reads (power of 2).
- TAG_DEPTH_N, 3, log2(TAG_DEPTH).
- STARVE_MAX, 16, consecutive lost arbitrations after which requester 1 is forced a grant.

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous reset, same effect as inRESET
- iMx_REQ  in  1  requester x (x=0,1) command valid
- oMx_BUSY  out  1  requester x command not accepted this cycle
- iMx_RW  in  1  1=write, 0=read
- iMx_ADDR  in  32  word address
- iMx_DATA  in  16  write data
- iMx_BYTEENA  in  2  byte enables
- oMx_VALID  out  1  read data valid to requester x
- iMx_BUSY  in  1  requester x cannot take read data
- oMx_DATA  out  16  read data
- oMEM_VALID  out  1  command valid to SDRAM
- oMEM_BYTEENA  out  2
- oMEM_RW  out  1
- oMEM_ADDR  out  32
- oMEM_DATA  out  16
- iMEM_BUSY  in  1  SDRAM cannot accept command
- iMEM_VALID  in  1  SDRAM read data valid
- iMEM_DATA  in  16
- oMEM_BUSY  out  1  back-pressure on read return
- oORPHAN  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset: inRESET low (async) or iRESET_SYNC high (sync) clears all state.
  - After reset: oMEM_VALID=0, oMEM_RW=0, oMEM_ADDR/DATA/BYTEENA=0, tag FIFO empty (count=0), starve counter=0, oORPHAN=0.
  - With the FIFO empty: oMx_VALID=0 and oMEM_BUSY=0.
- Command slot: a register holding {valid, rw, addr, data, byteena}, driven directly onto oMEM_*.
  - slot_free = !slot_valid || !iMEM_BUSY.
  - When iMEM_BUSY=1 and the slot is valid, all oMEM_* outputs are held stable.
  - When slot_free and no request is accepted, slot_valid clears next cycle.
- Eligibility: eligible_x = iMx_REQ && slot_free && !(iMx_RW==0 && tag_count==TAG_DEPTH).
  - A full FIFO blocks reads only, never writes.
  - Push is blocked at full even if a pop occurs in the same cycle.
- Grant (combinational, same cycle):
  - force1 = eligible_1 && starve==STARVE_MAX.
  - grant0 = eligible_0 && !force1.
  - grant1 = eligible_1 && (force1 || !eligible_0).
  - oMx_BUSY = !grant_x.
  - The granted command loads the slot at the next clock edge, so latency from request to oMEM_VALID is 1 cycle.
- Starve counter:
  - +1 (saturating at STARVE_MAX) when eligible_1 && grant0.
  - Cleared when grant1 or !iM1_REQ.
  - Holds otherwise.
- Tag FIFO: a 1-bit owner ID per entry.
  - Push on a granted read.
  - Head = oldest outstanding read.
- Read return: when iMEM_VALID && count!=0, route to the head owner in the same cycle.
  - oMh_VALID=1, oMh_DATA=iMEM_DATA; the other requester's VALID=0.
  - oMEM_BUSY = count!=0 && iMh_BUSY.
  - Pop when iMEM_VALID && !oMEM_BUSY.
  - Simultaneous push and pop leaves count unchanged.
- Orphan data: iMEM_VALID with count==0 is dropped and oORPHAN is set; it is cleared only by reset.
- oMx_DATA when not valid = iMEM_DATA (don't-care, unregistered).
- Reset mid-operation: the in-flight slot and all tags are discarded. SDRAM returns for pre-reset reads are treated as orphans.

Test Plan:
1. Both requesters request continuously; M0 reads, M1 writes; STARVE_MAX=16 -> pattern of 16 M0 grants then 1 M1 grant repeats; starve counter returns to 0 after each M1 grant.
2. M0 issues 8 reads with iMEM_VALID never asserted, TAG_DEPTH=8 -> 9th read gets oM0_BUSY=1; an M1 write in the same cycle is accepted.
3. iMEM_BUSY=1 for 5 cycles with the slot holding write addr 0x100, data 0x0F0F -> oMEM_* remain constant for all 5 cycles; the following request is accepted in the cycle iMEM_BUSY falls.
4. Interleaved reads M0@0x10, M1@0x20, M0@0x30; SDRAM returns 0xAAAA, 0xBBBB, 0xCCCC -> routed to M0, M1, M0 in order; iM1_BUSY=1 during the second return holds oMEM_BUSY=1 and delays the pop.
5. iMEM_VALID pulse with the FIFO empty -> no oMx_VALID; oORPHAN=1 and remains set until inRESET.
6. inRESET asserted with 3 reads outstanding and the slot valid -> oMEM_VALID=0 immediately (asynchronous); after release, count=0 and the next iMEM_VALID sets oORPHAN. iRESET_SYNC gives the same result one clock later.

Source files
------------

// File: rtl/vga_sdram_arbiter.sv
// Purpose: two-requester arbiter for the VGA SDRAM port; M0 (scan-out) has fixed priority, M1 gets starvation-guaranteed grants.
// Latency: 1 cycle from request to oMEM_VALID via the registered command slot; read returns are routed combinationally.
// Backpressure: oMx_BUSY when not granted (slot stalled, FIFO full for reads, or lost arbitration); oMEM_BUSY follows the head owner's iMx_BUSY.
//
// Ports:
//   iCLOCK, inRESET (async, active low), iRESET_SYNC (sync, active high)
//   iMx_REQ/RW/ADDR/DATA/BYTEENA -> oMx_BUSY       requester command side (x = 0, 1)
//   oMx_VALID/oMx_DATA <- iMx_BUSY                 read return to requester x
//   oMEM_VALID/RW/ADDR/DATA/BYTEENA <- iMEM_BUSY   command toward SDRAM
//   iMEM_VALID/iMEM_DATA -> oMEM_BUSY              read return from SDRAM
//   oORPHAN                                        sticky flag: return data with no outstanding tag
module vga_sdram_arbiter #(
  parameter int TAG_DEPTH   = 8,
  parameter int TAG_DEPTH_N = 3,
  parameter int STARVE_MAX  = 16
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  // requester 0
  input  logic        iM0_REQ,
  output logic        oM0_BUSY,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [15:0] iM0_DATA,
  input  logic [1:0]  iM0_BYTEENA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [15:0] oM0_DATA,
  // requester 1
  input  logic        iM1_REQ,
  output logic        oM1_BUSY,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [15:0] iM1_DATA,
  input  logic [1:0]  iM1_BYTEENA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [15:0] oM1_DATA,
  // SDRAM side
  output logic        oMEM_VALID,
  output logic [1:0]  oMEM_BYTEENA,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [15:0] oMEM_DATA,
  input  logic        iMEM_BUSY,
  input  logic        iMEM_VALID,
  input  logic [15:0] iMEM_DATA,
  output logic        oMEM_BUSY,
  output logic        oORPHAN
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  // command slot
  logic        slot_valid;
  logic        slot_rw;
  logic [31:0] slot_addr;
  logic [15:0] slot_data;
  logic [1:0]  slot_be;

  // starvation counter for requester 1
  logic [SW-1:0] starve;

  // tag FIFO: one owner bit per outstanding read
  logic                   tag_mem [TAG_DEPTH];
  logic [TAG_DEPTH_N-1:0] wr_ptr;
  logic [TAG_DEPTH_N-1:0] rd_ptr;
  logic [TAG_DEPTH_N:0]   tag_count;
  logic                   orphan;

  logic slot_free;
  logic tag_full;
  logic have_tag;
  logic head_owner;
  logic eligible0, eligible1;
  logic force1, grant0, grant1;
  logic push, pop;
  logic ret_busy;

  always_comb begin
    slot_free  = !slot_valid || !iMEM_BUSY;
    tag_full   = (tag_count == (TAG_DEPTH_N + 1)'(TAG_DEPTH));
    have_tag   = (tag_count != '0);
    head_owner = tag_mem[rd_ptr];

    // A full tag FIFO blocks reads only; writes need no tag.
    eligible0 = iM0_REQ && slot_free && !(!iM0_RW && tag_full);
    eligible1 = iM1_REQ && slot_free && !(!iM1_RW && tag_full);

    force1 = eligible1 && (starve == SW'(STARVE_MAX));
    grant0 = eligible0 && !force1;
    grant1 = eligible1 && (force1 || !eligible0);

    push = (grant0 && !iM0_RW) || (grant1 && !iM1_RW);

    // Return back-pressure comes from whichever requester owns the oldest read.
    ret_busy = have_tag && (head_owner ? iM1_BUSY : iM0_BUSY);
    pop      = iMEM_VALID && have_tag && !ret_busy;
  end

  assign oM0_BUSY     = !grant0;
  assign oM1_BUSY     = !grant1;
  assign oMEM_VALID   = slot_valid;
  assign oMEM_RW      = slot_rw;
  assign oMEM_ADDR    = slot_addr;
  assign oMEM_DATA    = slot_data;
  assign oMEM_BYTEENA = slot_be;
  assign oMEM_BUSY    = ret_busy;
  assign oM0_VALID    = iMEM_VALID && have_tag && !head_owner;
  assign oM1_VALID    = iMEM_VALID && have_tag &&  head_owner;
  assign oM0_DATA     = iMEM_DATA;
  assign oM1_DATA     = iMEM_DATA;
  assign oORPHAN      = orphan;

  // Owner storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge iCLOCK) begin
    if (push) tag_mem[wr_ptr] <= grant1;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      slot_valid <= 1'b0;
      slot_rw    <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_be    <= '0;
      starve     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      orphan     <= 1'b0;
    end else if (iRESET_SYNC) begin
      slot_valid <= 1'b0;
      slot_rw    <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_be    <= '0;
      starve     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      orphan     <= 1'b0;
    end else begin
      // Slot only changes when SDRAM has taken (or never had) its contents.
      if (slot_free) begin
        if (grant0) begin
          slot_valid <= 1'b1;
          slot_rw    <= iM0_RW;
          slot_addr  <= iM0_ADDR;
          slot_data  <= iM0_DATA;
          slot_be    <= iM0_BYTEENA;
        end else if (grant1) begin
          slot_valid <= 1'b1;
          slot_rw    <= iM1_RW;
          slot_addr  <= iM1_ADDR;
          slot_data  <= iM1_DATA;
          slot_be    <= iM1_BYTEENA;
        end else begin
          slot_valid <= 1'b0;
        end
      end

      // Count only arbitrations M1 actually lost to M0.
      if (grant1 || !iM1_REQ)
        starve <= '0;
      else if (eligible1 && grant0 && (starve != SW'(STARVE_MAX)))
        starve <= starve + 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase

      if (iMEM_VALID && !have_tag) orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sdram_arbiter.sv
module tb_vga_sdram_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iM0_REQ, iM0_RW, iM0_BUSY;
  logic [31:0] iM0_ADDR;
  logic [15:0] iM0_DATA;
  logic [1:0]  iM0_BYTEENA;
  logic        iM1_REQ, iM1_RW, iM1_BUSY;
  logic [31:0] iM1_ADDR;
  logic [15:0] iM1_DATA;
  logic [1:0]  iM1_BYTEENA;
  logic        iMEM_BUSY, iMEM_VALID;
  logic [15:0] iMEM_DATA;
  logic        oM0_BUSY, oM0_VALID, oM1_BUSY, oM1_VALID;
  logic [15:0] oM0_DATA, oM1_DATA;
  logic        oMEM_VALID, oMEM_RW, oMEM_BUSY, oORPHAN;
  logic [1:0]  oMEM_BYTEENA;
  logic [31:0] oMEM_ADDR;
  logic [15:0] oMEM_DATA;

  vga_sdram_arbiter #(.TAG_DEPTH(8), .TAG_DEPTH_N(3), .STARVE_MAX(16)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iM0_REQ(iM0_REQ), .oM0_BUSY(oM0_BUSY), .iM0_RW(iM0_RW), .iM0_ADDR(iM0_ADDR),
    .iM0_DATA(iM0_DATA), .iM0_BYTEENA(iM0_BYTEENA), .oM0_VALID(oM0_VALID),
    .iM0_BUSY(iM0_BUSY), .oM0_DATA(oM0_DATA),
    .iM1_REQ(iM1_REQ), .oM1_BUSY(oM1_BUSY), .iM1_RW(iM1_RW), .iM1_ADDR(iM1_ADDR),
    .iM1_DATA(iM1_DATA), .iM1_BYTEENA(iM1_BYTEENA), .oM1_VALID(oM1_VALID),
    .iM1_BUSY(iM1_BUSY), .oM1_DATA(oM1_DATA),
    .oMEM_VALID(oMEM_VALID), .oMEM_BYTEENA(oMEM_BYTEENA), .oMEM_RW(oMEM_RW),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .iMEM_BUSY(iMEM_BUSY),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA), .oMEM_BUSY(oMEM_BUSY),
    .oORPHAN(oORPHAN)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } cmd_t;

  typedef struct packed {
    logic        owner;
    logic [15:0] data;
  } ret_t;

  cmd_t exp_cmd_q[$];
  ret_t exp_ret_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic rw, input logic [31:0] addr, input logic [15:0] data,
                          input logic [1:0] be);
    cmd_t c;
    c = '{rw: rw, addr: addr, data: data, be: be};
    exp_cmd_q.push_back(c);
  endtask

  task automatic push_ret(input logic owner, input logic [15:0] data);
    ret_t r;
    r = '{owner: owner, data: data};
    exp_ret_q.push_back(r);
  endtask

  // Command monitor: every command SDRAM accepts must be the next expected one.
  always @(negedge iCLOCK) begin
    cmd_t act, exp;
    if (oMEM_VALID && !iMEM_BUSY) begin
      act = '{rw: oMEM_RW, addr: oMEM_ADDR, data: oMEM_DATA, be: oMEM_BYTEENA};
      if (exp_cmd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cmd: got 0x%0h expected none", act);
      end else begin
        exp = exp_cmd_q.pop_front();
        check("mem_cmd", 64'(act), 64'(exp));
      end
    end
  end

  // Return monitor: every read word taken by a requester must match owner and data order.
  always @(negedge iCLOCK) begin
    ret_t act, exp;
    if ((oM0_VALID && !iM0_BUSY) || (oM1_VALID && !iM1_BUSY)) begin
      act = oM1_VALID ? '{owner: 1'b1, data: oM1_DATA} : '{owner: 1'b0, data: oM0_DATA};
      if (exp_ret_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ret: got 0x%0h expected none", act);
      end else begin
        exp = exp_ret_q.pop_front();
        check("read_ret", 64'(act), 64'(exp));
      end
    end
  end

  task automatic idle();
    iM0_REQ = 0; iM0_RW = 0; iM0_ADDR = '0; iM0_DATA = '0; iM0_BYTEENA = 2'b11; iM0_BUSY = 0;
    iM1_REQ = 0; iM1_RW = 0; iM1_ADDR = '0; iM1_DATA = '0; iM1_BYTEENA = 2'b11; iM1_BUSY = 0;
    iMEM_BUSY = 0; iMEM_VALID = 0; iMEM_DATA = '0;
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    inRESET = 0;
    repeat (2) @(posedge iCLOCK);
    #1 inRESET = 1;
  endtask

  initial begin
    idle();
    do_reset();

    // ---- reset state ----
    iM0_BUSY = 1; iM1_BUSY = 1;
    @(negedge iCLOCK);
    check("rst_mem_valid", 64'(oMEM_VALID), 64'(0));
    check("rst_mem_rw", 64'(oMEM_RW), 64'(0));
    check("rst_mem_addr", 64'(oMEM_ADDR), 64'(0));
    check("rst_mem_data", 64'(oMEM_DATA), 64'(0));
    check("rst_mem_be", 64'(oMEM_BYTEENA), 64'(0));
    check("rst_orphan", 64'(oORPHAN), 64'(0));
    check("rst_m0_valid", 64'(oM0_VALID), 64'(0));
    check("rst_m1_valid", 64'(oM1_VALID), 64'(0));
    check("rst_mem_busy", 64'(oMEM_BUSY), 64'(0));
    tick();
    idle();

    // ---- 1: starvation pattern, 16 M0 grants then 1 M1 grant ----
    iM0_REQ = 1; iM0_RW = 0; iM1_REQ = 1; iM1_RW = 1; iM1_DATA = 16'h1234;
    iMEM_DATA = 16'h5A5A;
    for (int k = 0; k < 34; k++) begin
      iM0_ADDR = 32'h1000 + k;
      iM1_ADDR = 32'h2000 + k;
      // returns only when a read from the previous cycle is outstanding
      iMEM_VALID = (k != 0) && (k % 17 != 0);
      if (k % 17 == 16) begin
        push_cmd(1'b1, 32'h2000 + k, 16'h1234, 2'b11);
      end else begin
        push_cmd(1'b0, 32'h1000 + k, 16'h0000, 2'b11);
        push_ret(1'b0, 16'h5A5A);
      end
      @(negedge iCLOCK);
      check("t1_m0_busy", 64'(oM0_BUSY), 64'(k % 17 == 16));
      check("t1_m1_busy", 64'(oM1_BUSY), 64'(k % 17 != 16));
      tick();
    end
    idle();
    @(negedge iCLOCK);
    check("t1_no_orphan", 64'(oORPHAN), 64'(0));
    tick();

    // ---- 2: tag FIFO full blocks the 9th read but not a write ----
    do_reset();
    for (int k = 0; k < 8; k++) begin
      iM0_REQ = 1; iM0_RW = 0; iM0_ADDR = 32'h300 + k;
      push_cmd(1'b0, 32'h300 + k, 16'h0000, 2'b11);
      @(negedge iCLOCK);
      check("t2_read_accept", 64'(oM0_BUSY), 64'(0));
      tick();
    end
    iM0_ADDR = 32'h308;
    iM1_REQ = 1; iM1_RW = 1; iM1_ADDR = 32'h400; iM1_DATA = 16'hBEEF;
    push_cmd(1'b1, 32'h400, 16'hBEEF, 2'b11);
    @(negedge iCLOCK);
    check("t2_full_m0_busy", 64'(oM0_BUSY), 64'(1));
    check("t2_full_m1_write", 64'(oM1_BUSY), 64'(0));
    tick();
    idle();
    tick();

    // ---- 3: slot holds stable under iMEM_BUSY ----
    do_reset();
    iM0_REQ = 1; iM0_RW = 1; iM0_ADDR = 32'h100; iM0_DATA = 16'h0F0F;
    push_cmd(1'b1, 32'h100, 16'h0F0F, 2'b11);
    @(negedge iCLOCK);
    check("t3_first_grant", 64'(oM0_BUSY), 64'(0));
    tick();
    idle();
    iMEM_BUSY = 1;
    iM1_REQ = 1; iM1_RW = 1; iM1_ADDR = 32'h200; iM1_DATA = 16'h3333; iM1_BYTEENA = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLOCK);
      check("t3_hold_valid", 64'(oMEM_VALID), 64'(1));
      check("t3_hold_addr", 64'(oMEM_ADDR), 64'(32'h100));
      check("t3_hold_data", 64'(oMEM_DATA), 64'(16'h0F0F));
      check("t3_hold_rw", 64'(oMEM_RW), 64'(1));
      check("t3_hold_be", 64'(oMEM_BYTEENA), 64'(2'b11));
      check("t3_m1_stalled", 64'(oM1_BUSY), 64'(1));
      tick();
    end
    iMEM_BUSY = 0;
    push_cmd(1'b1, 32'h200, 16'h3333, 2'b01);
    @(negedge iCLOCK);
    check("t3_accept_on_release", 64'(oM1_BUSY), 64'(0));
    tick();
    idle();
    tick();
    tick();
    check("t3_slot_cleared", 64'(oMEM_VALID), 64'(0));

    // ---- 4: in-order return routing with back-pressure ----
    do_reset();
    iM0_REQ = 1; iM0_RW = 0; iM0_ADDR = 32'h10;
    push_cmd(1'b0, 32'h10, 16'h0000, 2'b11);
    tick();
    iM0_REQ = 0;
    iM1_REQ = 1; iM1_RW = 0; iM1_ADDR = 32'h20;
    push_cmd(1'b0, 32'h20, 16'h0000, 2'b11);
    tick();
    iM1_REQ = 0;
    iM0_REQ = 1; iM0_ADDR = 32'h30;
    push_cmd(1'b0, 32'h30, 16'h0000, 2'b11);
    tick();
    idle();
    push_ret(1'b0, 16'hAAAA);
    push_ret(1'b1, 16'hBBBB);
    push_ret(1'b0, 16'hCCCC);
    iMEM_VALID = 1; iMEM_DATA = 16'hAAAA;
    @(negedge iCLOCK);
    check("t4_r1_m0_valid", 64'(oM0_VALID), 64'(1));
    check("t4_r1_m1_valid", 64'(oM1_VALID), 64'(0));
    tick();
    iMEM_DATA = 16'hBBBB; iM1_BUSY = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge iCLOCK);
      check("t4_r2_mem_busy", 64'(oMEM_BUSY), 64'(1));
      check("t4_r2_m1_valid", 64'(oM1_VALID), 64'(1));
      check("t4_r2_m0_valid", 64'(oM0_VALID), 64'(0));
      tick();
    end
    iM1_BUSY = 0;
    @(negedge iCLOCK);
    check("t4_r2_released", 64'(oMEM_BUSY), 64'(0));
    tick();
    iMEM_DATA = 16'hCCCC;
    @(negedge iCLOCK);
    check("t4_r3_m0_valid", 64'(oM0_VALID), 64'(1));
    tick();
    idle();
    @(negedge iCLOCK);
    check("t4_no_orphan", 64'(oORPHAN), 64'(0));
    tick();

    // ---- 5: orphan return with empty FIFO ----
    do_reset();
    iMEM_VALID = 1; iMEM_DATA = 16'h7777;
    @(negedge iCLOCK);
    check("t5_m0_valid", 64'(oM0_VALID), 64'(0));
    check("t5_m1_valid", 64'(oM1_VALID), 64'(0));
    check("t5_orphan_before_edge", 64'(oORPHAN), 64'(0));
    tick();
    idle();
    @(negedge iCLOCK);
    check("t5_orphan_set", 64'(oORPHAN), 64'(1));
    repeat (3) tick();
    check("t5_orphan_sticky", 64'(oORPHAN), 64'(1));
    do_reset();
    @(negedge iCLOCK);
    check("t5_orphan_cleared", 64'(oORPHAN), 64'(0));
    tick();

    // ---- 6a: async reset with 3 reads outstanding and the slot valid ----
    for (int k = 0; k < 3; k++) begin
      iM0_REQ = 1; iM0_RW = 0; iM0_ADDR = 32'h500 + k;
      push_cmd(1'b0, 32'h500 + k, 16'h0000, 2'b11);
      tick();
    end
    idle();
    @(negedge iCLOCK);
    check("t6a_slot_valid", 64'(oMEM_VALID), 64'(1));
    #1 inRESET = 0;
    #1 check("t6a_async_clear", 64'(oMEM_VALID), 64'(0));
    #1 inRESET = 1;
    tick();
    iMEM_VALID = 1; iMEM_DATA = 16'h1111;
    @(negedge iCLOCK);
    check("t6a_no_route", 64'(oM0_VALID), 64'(0));
    check("t6a_no_busy", 64'(oMEM_BUSY), 64'(0));
    tick();
    idle();
    @(negedge iCLOCK);
    check("t6a_orphan", 64'(oORPHAN), 64'(1));
    tick();

    // ---- 6b: synchronous reset, effect one clock later ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      iM0_REQ = 1; iM0_RW = 0; iM0_ADDR = 32'h600 + k;
      push_cmd(1'b0, 32'h600 + k, 16'h0000, 2'b11);
      tick();
    end
    // this write would load the slot were it not for the sync reset
    iM0_RW = 1; iM0_ADDR = 32'h700; iM0_DATA = 16'h9999;
    iRESET_SYNC = 1;
    @(negedge iCLOCK);
    check("t6b_slot_still_valid", 64'(oMEM_VALID), 64'(1));
    tick();
    iRESET_SYNC = 0;
    idle();
    @(negedge iCLOCK);
    check("t6b_sync_clear", 64'(oMEM_VALID), 64'(0));
    check("t6b_orphan_clear", 64'(oORPHAN), 64'(0));
    tick();
    iMEM_VALID = 1; iMEM_DATA = 16'h2222;
    @(negedge iCLOCK);
    check("t6b_no_route", 64'(oM0_VALID), 64'(0));
    tick();
    idle();
    @(negedge iCLOCK);
    check("t6b_orphan", 64'(oORPHAN), 64'(1));
    tick();

    check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'(0));
    check("ret_queue_drained", 64'(exp_ret_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
